// File: rtl/mutative_types.sv
// rtl/mutative_types.sv - shared constants, FSM state enum and reset pattern for the memory responder
package mutative_types;

   localparam int OFFSET_BITS = 5;
   localparam int LINE_BITS   = 256;
   localparam int LINE_WORDS  = LINE_BITS / 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_resp_state_t;

   // Power-on contents of line i: 32-bit word w holds i*8+w, so every line is distinguishable
   function automatic logic [LINE_BITS-1:0] reset_line(input int unsigned i);
      logic [LINE_BITS-1:0] line;
      line = '0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         line[w*32 +: 32] = 32'(i * LINE_WORDS + w);
      end
      return line;
   endfunction

endpackage

// File: rtl/mutative_mem_responder_if.sv
// rtl/mutative_mem_responder_if.sv - line request/response bus between a requester and the responder
interface mutative_mem_responder_if;
   import mutative_types::*;

   logic [31:0]          dfp_addr;
   logic                 dfp_read;
   logic                 dfp_write;
   logic [LINE_BITS-1:0] dfp_wdata;
   logic [LINE_BITS-1:0] dfp_rdata;
   logic                 dfp_resp;

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp
   );

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp
   );

endinterface

// File: rtl/mutative_mem_array.sv
// rtl/mutative_mem_array.sv - flop-based line store with one combinational read port and one line write port
module mutative_mem_array
   import mutative_types::*;
#(
   parameter int LINES    = 64,
   parameter int IDX_BITS = $clog2(LINES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IDX_BITS-1:0]  rd_idx,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 we,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [LINE_BITS-1:0] wr_data
);

   logic [LINE_BITS-1:0] mem [LINES];

   // Store: reset restores the index pattern, otherwise one full line per write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) begin
            mem[i] <= reset_line(i);
         end
      end else if (we) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mutative_mem_responder.sv
// rtl/mutative_mem_responder.sv - fixed-latency line memory responder with abort detection and counters
module mutative_mem_responder
   import mutative_types::*;
#(
   parameter int LATENCY = 4,
   parameter int LINES   = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   mutative_mem_responder_if.slave  bus,
   output logic                     busy,
   output logic                     err,
   output logic [15:0]              rd_count,
   output logic [15:0]              wr_count
);

   localparam int IDX_BITS = $clog2(LINES);

   mem_resp_state_t      state;
   mem_resp_state_t      state_next;
   logic [3:0]           cnt;
   logic [IDX_BITS-1:0]  idx_q;
   logic                 op_write;
   logic [LINE_BITS-1:0] wdata_q;
   logic [LINE_BITS-1:0] mem_rd_data;
   logic [IDX_BITS-1:0]  idx_in;
   logic                 req_hold;
   logic                 accept;
   logic                 finish;
   logic                 abort;
   logic                 unused_addr;

   // Only the index field selects a line; offset and high bits alias
   assign idx_in      = bus.dfp_addr[OFFSET_BITS +: IDX_BITS];
   assign unused_addr = ^{bus.dfp_addr[31:OFFSET_BITS+IDX_BITS], bus.dfp_addr[OFFSET_BITS-1:0]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus accept/finish/abort decisions; the accepted op's own strobe must stay high
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      abort      = 1'b0;
      req_hold   = op_write ? bus.dfp_write : bus.dfp_read;
      case (state)
         IDLE: begin
            if (bus.dfp_read || bus.dfp_write) begin
               accept     = 1'b1;
               state_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!req_hold) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (cnt == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
            if (!req_hold) begin
               abort = 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, latency countdown, sticky error and completion counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx_q    <= '0;
         op_write <= 1'b0;
         wdata_q  <= '0;
         err      <= 1'b0;
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (accept) begin
            idx_q    <= idx_in;
            op_write <= bus.dfp_write;
            wdata_q  <= bus.dfp_wdata;
            cnt      <= 4'(LATENCY - 1);
            if (bus.dfp_read && bus.dfp_write) begin
               err <= 1'b1;
            end
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (abort) begin
            err <= 1'b1;
         end
         if (finish) begin
            if (op_write) begin
               wr_count <= wr_count + 16'd1;
            end else begin
               rd_count <= rd_count + 16'd1;
            end
         end
      end
   end

   mutative_mem_array #(
      .LINES    (LINES),
      .IDX_BITS (IDX_BITS)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (idx_q),
      .rd_data (mem_rd_data),
      .we      (finish && op_write),
      .wr_idx  (idx_q),
      .wr_data (wdata_q)
   );

   assign busy          = (state != IDLE);
   assign bus.dfp_resp  = (state == RESP);
   assign bus.dfp_rdata = (state == RESP && !op_write) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mutative_mem_responder.sv
// tb/tb_mutative_mem_responder.sv - directed scoreboard bench for the memory responder
module tb_mutative_mem_responder;

   typedef struct {
      logic [255:0] data;
      bit           is_rd;
      int           lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy4, err4, busy1, err1;
   logic [15:0] rdc4, wrc4, rdc1, wrc1;

   int           checks = 0;
   int           errors = 0;
   exp_t         sb[$];
   logic [255:0] model [64];

   always #5 clk = ~clk;

   mutative_mem_responder_if b4();
   mutative_mem_responder_if b1();

   mutative_mem_responder #(.LATENCY(4), .LINES(64)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (b4),
      .busy     (busy4),
      .err      (err4),
      .rd_count (rdc4),
      .wr_count (wrc4)
   );

   mutative_mem_responder #(.LATENCY(1), .LINES(64)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (b1),
      .busy     (busy1),
      .err      (err1),
      .rd_count (rdc1),
      .wr_count (wrc1)
   );

   function automatic logic [255:0] pat(input int i);
      logic [255:0] v;
      v = '0;
      for (int w = 0; w < 8; w++) begin
         v[w*32 +: 32] = 32'(i * 8 + w);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic txn4(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [255:0] wd);
      exp_t e;
      int   n;
      bit   got;
      int   li;
      li = int'((a >> 5) & 32'h3F);
      @(posedge clk);
      #1;
      b4.dfp_read  = rd;
      b4.dfp_write = wr;
      b4.dfp_addr  = a;
      b4.dfp_wdata = wd;
      sb.push_back('{data: (rd && !wr) ? model[li] : '0, is_rd: (rd && !wr), lat: 4});
      @(negedge clk);
      chk({tag, "_busy_pre"}, 256'(busy4), 256'(0));
      got = 1'b0;
      n   = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({tag, "_busy"}, 256'(busy4), 256'(1));
            b4.dfp_addr  = a ^ 32'h0000_07E0;
            b4.dfp_wdata = ~wd;
         end
         if (b4.dfp_resp) begin
            got = 1'b1;
            e   = sb.pop_front();
            chk({tag, "_latency"}, 256'(n), 256'(e.lat));
            if (e.is_rd) chk({tag, "_rdata"}, b4.dfp_rdata, e.data);
            if (wr) model[li] = wd;
         end else if (b4.dfp_rdata !== '0) begin
            chk({tag, "_rdata_idle"}, b4.dfp_rdata, '0);
         end
      end
      chk({tag, "_resp_seen"}, 256'(got), 256'(1));
   endtask

   task automatic release4();
      @(posedge clk);
      #1;
      b4.dfp_read  = 1'b0;
      b4.dfp_write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit   saw;
      bit   prev;
      bit   consec;
      int   nresp;

      rst_n        = 1'b0;
      b4.dfp_read  = 1'b0;
      b4.dfp_write = 1'b0;
      b4.dfp_addr  = '0;
      b4.dfp_wdata = '0;
      b1.dfp_read  = 1'b0;
      b1.dfp_write = 1'b0;
      b1.dfp_addr  = '0;
      b1.dfp_wdata = '0;
      for (int i = 0; i < 64; i++) model[i] = pat(i);

      #2;
      chk("rst_resp",  256'(b4.dfp_resp), 256'(0));
      chk("rst_rdata", b4.dfp_rdata, '0);
      chk("rst_busy",  256'(busy4), 256'(0));
      chk("rst_err",   256'(err4), 256'(0));
      chk("rst_rdc",   256'(rdc4), 256'(0));
      chk("rst_wrc",   256'(wrc4), 256'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // read of line 2 with the default latency
      txn4("rd40", 1'b1, 1'b0, 32'h0000_0040, '0);
      release4();
      chk("rd40_rdc", 256'(rdc4), 256'(1));

      // write then immediate read of the same line, no idle gap
      txn4("wr100", 1'b0, 1'b1, 32'h0000_0100, {8{32'hDEAD_BEEF}});
      txn4("rd100", 1'b1, 1'b0, 32'h0000_0100, '0);
      release4();
      chk("b2b_wrc", 256'(wrc4), 256'(1));
      chk("b2b_rdc", 256'(rdc4), 256'(2));

      // address aliasing onto line 0
      txn4("rd800", 1'b1, 1'b0, 32'h0000_0800, '0);
      release4();
      chk("pre_abort_err", 256'(err4), 256'(0));

      // write aborted by dropping dfp_write in WAIT
      @(posedge clk);
      #1;
      b4.dfp_write = 1'b1;
      b4.dfp_addr  = 32'h0000_0140;
      b4.dfp_wdata = {8{32'h1234_5678}};
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      b4.dfp_write = 1'b0;
      saw = b4.dfp_resp;
      @(negedge clk);
      chk("abort_busy", 256'(busy4), 256'(0));
      chk("abort_err",  256'(err4), 256'(1));
      repeat (6) begin
         @(negedge clk);
         if (b4.dfp_resp) saw = 1'b1;
      end
      chk("abort_no_resp", 256'(saw), 256'(0));
      chk("abort_wrc", 256'(wrc4), 256'(1));
      txn4("rd140", 1'b1, 1'b0, 32'h0000_0140, '0);
      release4();

      // LATENCY=1 responder: continuous read yields a response every second cycle
      @(posedge clk);
      #1;
      b1.dfp_read = 1'b1;
      b1.dfp_addr = 32'h0000_0060;
      repeat (4) sb.push_back('{data: pat(3), is_rd: 1'b1, lat: 1});
      nresp  = 0;
      prev   = 1'b0;
      consec = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k == 8) b1.dfp_read = 1'b0;
         if (b1.dfp_resp) begin
            nresp++;
            if (prev) consec = 1'b1;
            if (sb.size() != 0) e = sb.pop_front();
            else e = '{data: '0, is_rd: 1'b1, lat: 0};
            chk("lat1_rdata", b1.dfp_rdata, e.data);
         end
         prev = b1.dfp_resp;
      end
      chk("lat1_nresp",  256'(nresp), 256'(4));
      chk("lat1_consec", 256'(consec), 256'(0));
      chk("lat1_sb_empty", 256'(sb.size()), 256'(0));
      @(posedge clk);
      #1;
      chk("lat1_rdc", 256'(rdc1), 256'(4));
      chk("lat1_err", 256'(err1), 256'(0));

      // reset pulse in the middle of a pending write
      @(posedge clk);
      #1;
      b4.dfp_write = 1'b1;
      b4.dfp_addr  = 32'h0000_0100;
      b4.dfp_wdata = {8{32'hCAFE_F00D}};
      @(negedge clk);
      @(negedge clk);
      chk("midrst_busy_pre", 256'(busy4), 256'(1));
      #1;
      rst_n        = 1'b0;
      b4.dfp_write = 1'b0;
      #1;
      chk("midrst_busy",  256'(busy4), 256'(0));
      chk("midrst_err",   256'(err4), 256'(0));
      chk("midrst_rdc",   256'(rdc4), 256'(0));
      chk("midrst_wrc",   256'(wrc4), 256'(0));
      chk("midrst_resp",  256'(b4.dfp_resp), 256'(0));
      chk("midrst_busy1", 256'(busy1), 256'(0));
      chk("midrst_rdc1",  256'(rdc1), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      saw   = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (b4.dfp_resp) saw = 1'b1;
      end
      chk("midrst_no_resp", 256'(saw), 256'(0));
      for (int i = 0; i < 64; i++) model[i] = pat(i);
      txn4("rd100_rst", 1'b1, 1'b0, 32'h0000_0100, '0);
      release4();

      // read and write together: flagged as error, executed as a write
      chk("both_err_pre", 256'(err4), 256'(0));
      txn4("both20", 1'b1, 1'b1, 32'h0000_0020, {8{32'hA5A5_0F0F}});
      release4();
      chk("both_err", 256'(err4), 256'(1));
      chk("both_wrc", 256'(wrc4), 256'(1));
      chk("both_rdc", 256'(rdc4), 256'(1));
      txn4("rd20", 1'b1, 1'b0, 32'h0000_0020, '0);
      release4();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mutative_mem_responder.md
MUTATIVE_MEM_RESPONDER -- requirements
Module: mutative_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4: cycles from request acceptance to dfp_resp; legal range 1..15.
REQ-002 The block SHALL have parameter LINES, default 64: number of 256-bit lines stored; power of two; IDX_BITS = log2(LINES).
REQ-003 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port dfp_addr, input, 32: line address; bits [OFFSET_BITS-1:0] ignored.
REQ-006 The block SHALL have port dfp_read, input, 1: line read request, held by the requester until dfp_resp.
REQ-007 The block SHALL have port dfp_write, input, 1: line write request, held by the requester until dfp_resp.
REQ-008 The block SHALL have port dfp_wdata, input, 256: write line data.
REQ-009 The block SHALL have port dfp_rdata, output, 256: read line data.
REQ-010 The block SHALL have port dfp_resp, output, 1: one-cycle completion pulse.
REQ-011 The block SHALL have port busy, output, 1: high in any state except IDLE.
REQ-012 The block SHALL have port err, output, 1: sticky protocol-error flag.
REQ-013 The block SHALL have ports rd_count and wr_count, output, 16 each: completed-read and completed-write counters.

Function
REQ-014 Line index SHALL be dfp_addr[OFFSET_BITS +: IDX_BITS]; higher address bits are ignored, so addresses alias modulo LINES lines.
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 In IDLE, dfp_read or dfp_write high SHALL accept the request: latch index, op and wdata, load the latency counter with LATENCY-1, and go to WAIT; with LATENCY=1, go directly to RESP.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0. dfp_resp SHALL therefore be high exactly LATENCY cycles after the acceptance edge.
REQ-018 In RESP, dfp_resp SHALL be 1 for exactly one cycle.
REQ-019 In RESP for a read, dfp_rdata SHALL equal the stored line at the latched index.
REQ-020 In RESP for a write, the latched wdata SHALL be committed to the store at the RESP-exit edge.
REQ-021 After RESP the FSM SHALL return to IDLE. A request present in the cycle after RESP SHALL be accepted then, with no idle gap required.
REQ-022 A read to a line written in the immediately preceding transaction SHALL return the new data.
REQ-023 dfp_rdata SHALL be 0 whenever dfp_resp is low.
REQ-024 Address and wdata changes after acceptance SHALL be ignored.
REQ-025 dfp_read and dfp_write both high at acceptance SHALL set err and be treated as a write.
REQ-026 If the accepted request signal drops in WAIT or RESP, the block SHALL abort: set err, return to IDLE next cycle, commit no write, and increment no counter. In RESP, the dfp_resp pulse SHALL still complete.
REQ-027 rd_count or wr_count SHALL increment by 1 at each completed read or write and SHALL wrap from 16'hFFFF to 0.
REQ-028 err SHALL be cleared only by reset.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, dfp_resp 0, dfp_rdata 0, busy 0, err 0, rd_count 0, wr_count 0 and counter 0.
REQ-030 rst_n low SHALL reset the store so that 32-bit word w (0..7) of line i holds 32'(i*8+w).
REQ-031 Reset asserted mid-transaction SHALL discard that transaction, with no commit and no dfp_resp.
REQ-032 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-033 OFFSET_BITS, the 256-bit line width and the state enum mem_resp_state_t SHALL live in the shared package mutative_types.
REQ-034 Line storage SHALL be the sub-module mutative_mem_array: LINES x 256 flops with async reset to the REQ-030 pattern, one combinational read port and one full-line write port.

Verification
REQ-035 Reset, then read addr 0x0000_0040 with LATENCY=4 -> dfp_resp on cycle 4 after acceptance; rdata words = 16..23; rd_count=1.
REQ-036 Write 256'h{8{32'hDEAD_BEEF}} to 0x0000_0100, then on the next cycle read 0x0000_0100 -> read returns all-DEADBEEF words; wr_count=1, rd_count=1; the second request is accepted the cycle after the first dfp_resp.
REQ-037 Read 0x0000_0800 with LINES=64 -> aliases to line 0; rdata words = 0..7.
REQ-038 dfp_read and dfp_write both high at 0x20 -> err=1; the line at 0x20 holds wdata after dfp_resp.
REQ-039 Write accepted, then dfp_write dropped in cycle 2 -> err=1; no dfp_resp; line unchanged; wr_count=0.
REQ-040 LATENCY=1 with back-to-back reads, and rst_n pulsed low mid-WAIT -> dfp_resp every second cycle; after the reset pulse, busy=0, counters=0 and the store is back to the reset pattern.
